// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with private HI/LO and the D-stage stall request.
// Optional madd/maddu/msub/msubu accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_D,
  output logic        busy,
  output logic        pause_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  localparam logic [3:0] MULT_N   = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N    = 4'(DIV_CYCLES);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_we_q, pend_we_d;

  logic [63:0] smul_s, umul_s;
  logic [31:0] a_mag_s, b_mag_s, udiv_s, sq_mag_s, sr_mag_s;
  logic [31:0] uq_s, ur_s, sq_s, sr_s;
  logic        long_op_s;

  // Signed product uses sign-extended 64-bit operands so the low 64 bits are exact.
  assign smul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign umul_s = {32'd0, A} * {32'd0, B};

  // Signed divide works on magnitudes; a zero divisor is replaced so no X is produced.
  assign a_mag_s  = A[31] ? (32'd0 - A) : A;
  assign b_mag_s  = (B == 32'd0) ? 32'd1 : (B[31] ? (32'd0 - B) : B);
  assign udiv_s   = (B == 32'd0) ? 32'd1 : B;
  assign uq_s     = A / udiv_s;
  assign ur_s     = A % udiv_s;
  assign sq_mag_s = a_mag_s / b_mag_s;
  assign sr_mag_s = a_mag_s % b_mag_s;
  assign sq_s     = (A[31] ^ B[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
  assign sr_s     = A[31] ? (32'd0 - sr_mag_s) : sr_mag_s;

  // Classify ops that occupy the unit for multiple cycles.
  always_comb begin
    long_op_s = 1'b0;
    if (start) begin
      case (op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op_s = 1'b1;
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: long_op_s = 1'b1;
`endif
        default: long_op_s = 1'b0;
      endcase
    end else begin
      long_op_s = 1'b0;
    end
  end

  // Next-state: op capture in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT:  begin pend_d = smul_s; pend_we_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
            OP_MULTU: begin pend_d = umul_s; pend_we_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
            OP_DIV:   begin pend_d = {sr_s, sq_s}; pend_we_d = (B != 32'd0); cnt_d = DIV_N; state_d = S_BUSY; end
            OP_DIVU:  begin pend_d = {ur_s, uq_s}; pend_we_d = (B != 32'd0); cnt_d = DIV_N; state_d = S_BUSY; end
            OP_MTHI:  hi_d = A;
            OP_MTLO:  lo_d = A;
`ifdef MDU_MADD_EN
            OP_MADD:  begin pend_d = {hi_q, lo_q} + smul_s; pend_we_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
            OP_MADDU: begin pend_d = {hi_q, lo_q} + umul_s; pend_we_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
            OP_MSUB:  begin pend_d = {hi_q, lo_q} - smul_s; pend_we_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
            OP_MSUBU: begin pend_d = {hi_q, lo_q} - umul_s; pend_we_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
`endif
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          if (pend_we_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end else begin
            hi_d = hi_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pend_q    <= 64'd0;
      pend_we_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q == S_BUSY);
  assign pause_md = md_D && (busy || long_op_s);
  assign HI       = hi_q;
  assign LO       = lo_q;

  mdu_ctrl_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy)
  );

endmodule

// Protocol checker: the hazard unit must never launch an op while the unit is busy.
module mdu_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic start,
  input logic busy
);
  a_no_start_busy: assert property (@(posedge clk) disable iff (!reset) !(start && busy));
endmodule
